// File: rtl/addsub_pkg.sv
// Shared types and constants for the byte-serial add/sub sequencer.
// Byte width is fixed by the 8-bit combinational adder it drives.
package addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;
  localparam int   BYTE_W = 8;

endpackage

// File: rtl/addsub_byte_serial_ctrl.sv
// Drives an 8-bit add/sub unit one byte per cycle to build an NBYTES-wide sum/difference.
// Result and flags arrive with a one-cycle done pulse NBYTES+1 cycles after start.
module addsub_byte_serial_ctrl
  import addsub_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     op,
  input  logic [BYTE_W*NBYTES-1:0] a,
  input  logic [BYTE_W*NBYTES-1:0] b,
  output logic                     busy,
  output logic                     done,
  output logic [BYTE_W*NBYTES-1:0] result,
  output logic                     cout,
  output logic                     ovf,
  output logic                     zero,
  output logic [BYTE_W-1:0]        add_x,
  output logic [BYTE_W-1:0]        add_y,
  output logic                     add_cin,
  output logic                     add_sig,
  input  logic [BYTE_W:0]          add_s,
  input  logic                     add_cout
);

  localparam int              W      = BYTE_W * NBYTES;
  localparam int              KW     = $clog2(NBYTES);
  localparam logic [KW-1:0]   K_LAST = KW'(NBYTES - 1);

  state_e          state_q;
  logic [KW-1:0]   k_q;
  logic [W-1:0]    a_q;
  logic [W-1:0]    b_q;
  logic            op_q;
  logic            carry_q;
  logic            busy_q;
  logic            done_q;
  logic [W-1:0]    result_q;
  logic [W-1:0]    result_d;
  logic            cout_q;
  logic            ovf_q;
  logic            zero_q;

  logic [BYTE_W-1:0] x_byte;
  logic [BYTE_W-1:0] y_byte;
  logic              unused_s8;

  assign unused_s8 = add_s[BYTE_W];

  // Subtraction is A + ~B + 1, so the adder always runs on its ripple-add path.
  always_comb begin
    x_byte = a_q[k_q*BYTE_W +: BYTE_W];
    y_byte = b_q[k_q*BYTE_W +: BYTE_W] ^ {BYTE_W{op_q == OP_SUB}};
  end

  always_comb begin
    result_d = result_q;
    result_d[k_q*BYTE_W +: BYTE_W] = add_s[BYTE_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      k_q      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= OP_ADD;
      carry_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            a_q     <= a;
            b_q     <= b;
            op_q    <= op;
            carry_q <= op;
            k_q     <= '0;
            busy_q  <= 1'b1;
            state_q <= RUN;
          end
        end
        RUN: begin
          result_q <= result_d;
          carry_q  <= add_cout;
          if (k_q == K_LAST) begin
            // Flags are taken from the live top byte so they line up with done.
            state_q <= FIN;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            cout_q  <= add_cout;
            ovf_q   <= (a_q[W-1] == y_byte[BYTE_W-1]) && (add_s[BYTE_W-1] != a_q[W-1]);
            zero_q  <= (result_d == '0);
          end else begin
            k_q <= k_q + 1'b1;
          end
        end
        FIN: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign ovf     = ovf_q;
  assign zero    = zero_q;
  assign add_x   = (state_q == RUN) ? x_byte  : '0;
  assign add_y   = (state_q == RUN) ? y_byte  : '0;
  assign add_cin = (state_q == RUN) ? carry_q : 1'b0;
  assign add_sig = 1'b1;

endmodule

// File: tb/tb_addsub_byte_serial_ctrl.sv
// Directed bench for the byte-serial add/sub sequencer with a behavioural 8-bit adder on its add_* ports.
module tb_addsub_byte_serial_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] result;
  logic        cout;
  logic        ovf;
  logic        zero;
  logic [7:0]  add_x;
  logic [7:0]  add_y;
  logic        add_cin;
  logic        add_sig;
  logic [8:0]  add_s;
  logic        add_cout;

  int total = 0;
  int bad   = 0;
  int cyc;
  logic busy_ok;
  logic sig_ok;
  logic done_seen;

  addsub_byte_serial_ctrl #(.NBYTES(4)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .result(result), .cout(cout), .ovf(ovf), .zero(zero),
    .add_x(add_x), .add_y(add_y), .add_cin(add_cin), .add_sig(add_sig),
    .add_s(add_s), .add_cout(add_cout)
  );

  // 8-bit adder: sig=1 ripple add with carry-in, sig=0 plain subtract.
  assign add_s    = add_sig ? ({1'b0, add_x} + {1'b0, add_y} + {8'b0, add_cin})
                            : ({1'b0, add_x} - {1'b0, add_y});
  assign add_cout = add_s[8];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h want=%h", tag, got, exp);
    end
  endtask

  task automatic start_op(input logic o, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    op = o; a = av; b = bv; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(output int n);
    n = 0; busy_ok = 1'b1; sig_ok = 1'b1;
    while (n < 20) begin
      @(negedge clk);
      n++;
      if (add_sig !== 1'b1) sig_ok = 1'b0;
      if (done === 1'b1) break;
      if (busy !== 1'b1) busy_ok = 1'b0;
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_result", result, 32'h0);
    chk("rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
    chk("rst_adder_in", {23'b0, add_x, add_cin}, 32'd0);
    chk("rst_add_y", {24'b0, add_y}, 32'd0);
    chk("rst_add_sig", {31'b0, add_sig}, 32'd1);
    rst = 1'b0;

    // add with carry into byte 1
    start_op(1'b0, 32'h000000FF, 32'h00000001);
    wait_done(cyc);
    chk("add1_latency", cyc, 32'd5);
    chk("add1_busy_run", {31'b0, busy_ok}, 32'd1);
    chk("add1_busy_fin", {31'b0, busy}, 32'd0);
    chk("add1_result", result, 32'h00000100);
    chk("add1_flags", {29'b0, cout, ovf, zero}, 32'b000);
    @(negedge clk);
    chk("add1_done_pulse", {31'b0, done}, 32'd0);
    chk("add1_hold", result, 32'h00000100);
    chk("idle_add_x", {24'b0, add_x}, 32'd0);

    // full carry ripple to zero
    start_op(1'b0, 32'hFFFFFFFF, 32'h00000001);
    wait_done(cyc);
    chk("add2_latency", cyc, 32'd5);
    chk("add2_result", result, 32'h00000000);
    chk("add2_flags", {29'b0, cout, ovf, zero}, 32'b101);

    // signed overflow on subtract
    start_op(1'b1, 32'h80000000, 32'h00000001);
    wait_done(cyc);
    chk("sub1_latency", cyc, 32'd5);
    chk("sub1_sig", {31'b0, sig_ok}, 32'd1);
    chk("sub1_result", result, 32'h7FFFFFFF);
    chk("sub1_flags", {29'b0, cout, ovf, zero}, 32'b110);

    // borrow
    start_op(1'b1, 32'h00000005, 32'h00000007);
    wait_done(cyc);
    chk("sub2_latency", cyc, 32'd5);
    chk("sub2_result", result, 32'hFFFFFFFE);
    chk("sub2_flags", {29'b0, cout, ovf, zero}, 32'b000);

    // starts during RUN and FIN are dropped; the one right after FIN is taken
    start_op(1'b0, 32'h01020304, 32'h10203040);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (i == 2) begin op = 1'b1; a = 32'hDEADBEEF; b = 32'h00000001; start = 1'b1; end
      if (i == 3) start = 1'b0;
      if (i == 5) begin
        chk("ign_done", {31'b0, done}, 32'd1);
        chk("ign_result", result, 32'h11223344);
        op = 1'b1; a = 32'hDEADBEEF; b = 32'h00000001; start = 1'b1;
      end
    end
    @(negedge clk);
    chk("ign_fin_start_busy", {31'b0, busy}, 32'd0);
    chk("ign_hold", result, 32'h11223344);
    op = 1'b0; a = 32'hAAAA0000; b = 32'h00005555; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(cyc);
    chk("acc_latency", cyc, 32'd5);
    chk("acc_result", result, 32'hAAAA5555);
    chk("acc_flags", {29'b0, cout, ovf, zero}, 32'b000);

    // reset while byte 2 is on the adder
    start_op(1'b0, 32'h0F0F0F0F, 32'h01010101);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_result", result, 32'h0);
    chk("mid_rst_ctrl", {30'b0, busy, done}, 32'd0);
    chk("mid_rst_flags", {29'b0, cout, ovf, zero}, 32'd0);
    chk("mid_rst_adder", {23'b0, add_x, add_cin}, 32'd0);
    chk("mid_rst_add_y", {24'b0, add_y}, 32'd0);
    rst = 1'b0;
    done_seen = 1'b0;
    repeat (8) begin
      @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) done_seen = 1'b1;
    end
    chk("mid_rst_no_done", {31'b0, done_seen}, 32'd0);

    start_op(1'b0, 32'h12345678, 32'h11111111);
    wait_done(cyc);
    chk("post_rst_latency", cyc, 32'd5);
    chk("post_rst_result", result, 32'h23456789);
    chk("post_rst_flags", {29'b0, cout, ovf, zero}, 32'b000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
